// File: rtl/switch_control.sv
// Per-output round-robin switch allocator: sanitises one-hot output requests,
// arbitrates each enabled output independently and registers the grants.

module switch_control_arb #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [0:N-1] req,
  output logic         win_vld,
  output logic [W-1:0] win_idx
);
  logic [W-1:0] ptr_q, ptr_d;
  int t;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    ptr_d   = ptr_q;
    t       = 0;
    // Scan from furthest to nearest so the nearest candidate at/after ptr wins.
    for (int k = N-1; k >= 0; k--) begin
      t = int'(ptr_q) + k;
      if (t >= N) t = t - N;
      if (en && req[t]) begin
        win_vld = 1'b1;
        win_idx = W'(t);
      end
    end
    if (win_vld)
      ptr_d = (int'(win_idx) == N-1) ? '0 : W'(int'(win_idx) + 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
endmodule

module switch_control #(
  parameter int N = 5,
  parameter int M = 5,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [0:N-1][0:M-1]  i_output_req,
  input  logic [0:M-1]         i_en,
  output logic [0:N-1][0:M-1]  o_output_grant,
  output logic [0:M-1][W-1:0]  o_output_sel,
  output logic [0:M-1]         o_output_val,
  output logic [0:N-1]         o_input_grant
);
  logic [0:N-1][0:M-1] eff_req;
  logic [0:M-1][0:N-1] col_req;
  logic [0:M-1]        win_vld;
  logic [0:M-1][W-1:0] win_idx;

  logic [0:N-1][0:M-1] grant_d, grant_q;
  logic [0:M-1][W-1:0] sel_d, sel_q;
  logic [0:M-1]        val_d, val_q;
  logic [0:N-1]        igrant_d, igrant_q;

  // Keep only the lowest-index requested output per input; this alone makes
  // input-side grants unique, so no second allocation pass is needed.
  always_comb begin
    eff_req = '0;
    for (int i = 0; i < N; i++)
      for (int j = M-1; j >= 0; j--)
        if (i_output_req[i][j]) begin
          eff_req[i]    = '0;
          eff_req[i][j] = 1'b1;
        end
  end

  for (genvar j = 0; j < M; j++) begin : g_out
    for (genvar i = 0; i < N; i++) begin : g_col
      assign col_req[j][i] = eff_req[i][j];
    end
    switch_control_arb #(.N(N), .W(W)) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (i_en[j]),
      .req     (col_req[j]),
      .win_vld (win_vld[j]),
      .win_idx (win_idx[j])
    );
  end

  always_comb begin
    grant_d  = '0;
    sel_d    = '0;
    val_d    = win_vld;
    igrant_d = '0;
    for (int j = 0; j < M; j++)
      if (win_vld[j]) begin
        grant_d[win_idx[j]][j] = 1'b1;
        sel_d[j]               = win_idx[j];
      end
    for (int i = 0; i < N; i++)
      igrant_d[i] = |grant_d[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q  <= '0;
      sel_q    <= '0;
      val_q    <= '0;
      igrant_q <= '0;
    end else begin
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      val_q    <= val_d;
      igrant_q <= igrant_d;
    end
  end

  assign o_output_grant = grant_q;
  assign o_output_sel   = sel_q;
  assign o_output_val   = val_q;
  assign o_input_grant  = igrant_q;
endmodule

// File: tb/tb_switch_control.sv
// Directed scoreboard bench for switch_control: per-step expected winners are
// queued when stimulus is driven and compared one cycle later.

module tb_switch_control;
  localparam logic [3:0] NO = 4'hf;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [0:4][0:4]     req;
  logic [0:4]          en;
  logic [0:4][0:4]     o_output_grant;
  logic [0:4][2:0]     o_output_sel;
  logic [0:4]          o_output_val;
  logic [0:4]          o_input_grant;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string           tag;
    logic [0:4][0:4] g;
    logic [0:4]      v;
    logic [0:4][2:0] s;
    logic [0:4]      ig;
  } exp_t;
  exp_t sb[$];

  switch_control #(.N(5), .M(5)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_output_req   (req),
    .i_en           (en),
    .o_output_grant (o_output_grant),
    .o_output_sel   (o_output_sel),
    .o_output_val   (o_output_val),
    .o_input_grant  (o_input_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".grant"}, 64'(o_output_grant), 64'd0);
    chk({tag, ".sel"},   64'(o_output_sel),   64'd0);
    chk({tag, ".val"},   64'(o_output_val),   64'd0);
    chk({tag, ".igr"},   64'(o_input_grant),  64'd0);
  endtask

  // Structural invariants on whatever the DUT currently drives.
  task automatic chk_inv(input string tag);
    logic [0:4] col_or;
    int cnt;
    for (int j = 0; j < 5; j++) begin
      cnt = 0;
      col_or[j] = 1'b0;
      for (int i = 0; i < 5; i++) begin
        cnt += int'(o_output_grant[i][j]);
        col_or[j] |= o_output_grant[i][j];
      end
      chk({tag, ".col_1hot"}, 64'(cnt <= 1), 64'd1);
      if (o_output_val[j])
        chk({tag, ".sel_cons"}, 64'(o_output_grant[o_output_sel[j]][j]), 64'd1);
      else
        chk({tag, ".sel_idle"}, 64'(o_output_sel[j]), 64'd0);
    end
    chk({tag, ".val_or"}, 64'(o_output_val), 64'(col_or));
    for (int i = 0; i < 5; i++)
      chk({tag, ".row_1hot"}, 64'($countones(o_output_grant[i]) <= 1), 64'd1);
  endtask

  task automatic check_out();
    exp_t x;
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'd0, 64'd1);
      return;
    end
    x = sb.pop_front();
    chk({x.tag, ".grant"}, 64'(o_output_grant), 64'(x.g));
    chk({x.tag, ".val"},   64'(o_output_val),   64'(x.v));
    chk({x.tag, ".sel"},   64'(o_output_sel),   64'(x.s));
    chk({x.tag, ".igr"},   64'(o_input_grant),  64'(x.ig));
    chk_inv(x.tag);
  endtask

  // w[j] = expected winning input of output j, or NO.
  task automatic step(input string tag, input logic [0:4][0:4] r,
                      input logic [0:4] e, input logic [0:4][3:0] w);
    exp_t x;
    @(negedge clk);
    req = r;
    en  = e;
    x.tag = tag; x.g = '0; x.v = '0; x.s = '0; x.ig = '0;
    for (int j = 0; j < 5; j++)
      if (w[j] != NO) begin
        x.g[w[j]][j] = 1'b1;
        x.v[j]       = 1'b1;
        x.s[j]       = w[j][2:0];
        x.ig[w[j]]   = 1'b1;
      end
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset with every request asserted.
    reset_n = 1'b0;
    req = {5{5'b11111}};
    en  = 5'b11111;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    req = '0;

    step("single",  {5'b0, 5'b0, 5'b00100, 5'b0, 5'b0},      5'b11111, {NO, NO, 4'd2, NO, NO});
    step("ptr2_3",  {5'b0, 5'b0, 5'b00100, 5'b00100, 5'b0},  5'b11111, {NO, NO, 4'd3, NO, NO});
    step("pulse",   '0,                                      5'b11111, {NO, NO, NO, NO, NO});

    // Round robin on output 1 from reset.
    do_reset();
    step("rr0", {5'b01000, 5'b01000, 5'b0, 5'b01000, 5'b0}, 5'b11111, {NO, 4'd0, NO, NO, NO});
    step("rr1", {5'b01000, 5'b01000, 5'b0, 5'b01000, 5'b0}, 5'b11111, {NO, 4'd1, NO, NO, NO});
    step("rr2", {5'b01000, 5'b01000, 5'b0, 5'b01000, 5'b0}, 5'b11111, {NO, 4'd3, NO, NO, NO});
    step("rr3", {5'b01000, 5'b01000, 5'b0, 5'b01000, 5'b0}, 5'b11111, {NO, 4'd0, NO, NO, NO});
    step("rr4", {5'b01000, 5'b01000, 5'b0, 5'b01000, 5'b0}, 5'b11111, {NO, 4'd1, NO, NO, NO});
    step("rr5", {5'b01000, 5'b01000, 5'b0, 5'b01000, 5'b0}, 5'b11111, {NO, 4'd3, NO, NO, NO});

    // Wrap-around on output 4.
    step("wrap_set", {5'b0, 5'b0, 5'b0, 5'b00001, 5'b0},      5'b11111, {NO, NO, NO, NO, 4'd3});
    step("wrap_hi",  {5'b00001, 5'b0, 5'b0, 5'b0, 5'b00001},  5'b11111, {NO, NO, NO, NO, 4'd4});
    step("wrap_lo",  {5'b00001, 5'b0, 5'b0, 5'b0, 5'b00001},  5'b11111, {NO, NO, NO, NO, 4'd0});

    // Back-pressure on output 0.
    step("bp0",     {5'b0, 5'b10000, 5'b0, 5'b0, 5'b0}, 5'b01111, {NO, NO, NO, NO, NO});
    step("bp1",     {5'b0, 5'b10000, 5'b0, 5'b0, 5'b0}, 5'b01111, {NO, NO, NO, NO, NO});
    step("bp2",     {5'b0, 5'b10000, 5'b0, 5'b0, 5'b0}, 5'b01111, {NO, NO, NO, NO, NO});
    step("bp_go",   {5'b0, 5'b10000, 5'b0, 5'b0, 5'b0}, 5'b11111, {4'd1, NO, NO, NO, NO});
    step("bp_next", {5'b10000, 5'b10000, 5'b0, 5'b0, 5'b0}, 5'b11111, {4'd0, NO, NO, NO, NO});

    // Parallel and multi-hot requests.
    do_reset();
    step("par", {5'b00010, 5'b01000, 5'b01100, 5'b0, 5'b0}, 5'b11111, {NO, 4'd1, NO, 4'd0, NO});
    chk("par.igr_lit", 64'(o_input_grant), 64'(5'b11000));
    step("mh_blocked", {5'b0, 5'b0, 5'b0, 5'b00011, 5'b0}, 5'b11101, {NO, NO, NO, NO, NO});
    step("mh_go",      {5'b0, 5'b0, 5'b0, 5'b00011, 5'b0}, 5'b11111, {NO, NO, NO, 4'd3, NO});

    // Contention, then asynchronous reset between edges.
    step("cont0", {5'b10000, 5'b10000, 5'b01000, 5'b01000, 5'b0}, 5'b11111, {4'd0, 4'd2, NO, NO, NO});
    step("cont1", {5'b10000, 5'b10000, 5'b0, 5'b0, 5'b0},         5'b11111, {4'd1, NO, NO, NO, NO});
    #2 reset_n = 1'b0;
    req = '0;
    #1 chk_zero("async_rst");
    @(posedge clk);
    #1 chk_zero("async_hold");
    @(negedge clk);
    reset_n = 1'b1;
    step("post_rst", {5'b01000, 5'b10000, 5'b0, 5'b01000, 5'b10000}, 5'b11111, {4'd1, 4'd0, NO, NO, NO});

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/switch_control.md
Name: switch_control

Overview:
- Per-output round-robin allocator directly downstream of the ant agent.
- Consumes the N x M one-hot output-request matrix, that is, each input's requested output port.
- Grants at most one input per output and at most one output per input each cycle, honouring a per-output enable from downstream.
- Drives registered grants to the switch one-hot datapath, and input pop strobes back to the input buffers.

Parameters:
- N, 5, number of input ports (local PE + 4 mesh directions).
- M, 5, number of output ports. Bit order is 0=PE(10000), 1=north(01000), 2=east(00100), 3=south(00010), 4=west(00001).

Ports:
- clk  input  1  system clock; rising-edge active.
- reset_n  input  1  asynchronous, active-low reset.
- i_output_req  input  [0:N-1][0:M-1]  per-input output request from the ant agent.
- i_en  input  [0:M-1]  output j may accept a flit this cycle (downstream credit/ready).
- o_output_grant  output  [0:N-1][0:M-1]  registered grant matrix; bit [i][j] means input i is switched to output j.
- o_output_sel  output  [0:M-1][$clog2(N)-1:0]  registered index of the input granted to output j.
- o_output_val  output  [0:M-1]  registered: output j carries a granted flit.
- o_input_grant  output  [0:N-1]  registered: input i was granted; this is the pop strobe to input buffer i.

Behaviour:
- State: one priority pointer ptr[j] per output, width $clog2(N), range 0..N-1. Plus the registered outputs.
- Reset (reset_n=0, asynchronous): all ptr[j]=0, o_output_grant='0, o_output_sel='0, o_output_val='0, o_input_grant='0. Reset mid-operation discards any grant in flight, and the first post-reset grant uses ptr=0.
- Request sanitising (combinational):
  - eff_req[i] = lowest-index set bit of i_output_req[i]; all others are cleared.
  - A multi-hot request is therefore treated as a request to its lowest-index output. A zero row makes no request.
- Arbitration (combinational, every cycle), for each output j with i_en[j]=1:
  - Candidates are inputs i with eff_req[i][j]=1.
  - Winner = first candidate found scanning i = ptr[j], ptr[j]+1, ..., wrapping modulo N.
  - With i_en[j]=0, or no candidate, output j has no winner.
- Input uniqueness: guaranteed by sanitising, since each input targets one output. No second allocation pass.
- Register update on rising clk edge:
  - o_output_grant[i][j] = 1 iff i won output j.
  - o_output_val[j] = 1 iff j has a winner.
  - o_output_sel[j] = winner index, else 0.
  - o_input_grant[i] = OR of row i of the new grant matrix.
- Pointer update on the same edge:
  - If output j had a winner w: ptr[j] = (w+1) mod N. w=N-1 wraps to 0; no arithmetic overflow past N-1 is permitted.
  - Otherwise ptr[j] holds. This includes i_en[j]=0 with pending requests.
- Latency: request sampled in cycle t; grant visible for exactly cycle t+1.
  - Grants are single-cycle pulses.
  - A request held over consecutive cycles is re-arbitrated each cycle. The requester is responsible for dropping or replacing the request after its pop strobe.
- Simultaneous events:
  - i_en[j] deasserting in the same cycle as a request means no grant for j.
  - Requests to different outputs are granted in the same cycle independently.
- Invariants (assert in bench):
  - Each column of o_output_grant has at most one bit set.
  - Each row has at most one bit set.
  - o_output_val[j] equals the column-j OR.
  - o_output_sel[j] is consistent with the grant column.

Test Plan:
- Reset check: hold reset_n=0 with all requests asserted -> all outputs 0. Release, then req[2]=00100, i_en=11111 -> next cycle o_output_grant[2]=00100, o_output_sel[2]=2, o_output_val=00100, o_input_grant=00100, ptr[2]=3.
- Round-robin fairness: inputs 0,1,3 all request 01000 continuously with i_en[1]=1 from reset -> grants on output 1 in order 0,1,3,0,1,3. o_output_sel[1] sequence is 0,1,3,0,1,3.
- Wrap-around: ptr[4]=4 (after input 3 wins), inputs 0 and 4 request 00001 -> input 4 wins, ptr[4] becomes 0. Next cycle input 0 wins.
- Back-pressure: input 1 requests 10000 with i_en[0]=0 for 3 cycles, then i_en[0]=1 -> no grant and ptr[0] unchanged for 3 cycles. Grant to input 1 appears in the cycle after i_en[0] rises.
- Parallel and illegal requests: req[0]=00010, req[1]=01000, req[2]=01100 (multi-hot), ptr=0 -> input 0 gets output 3, and input 1 gets output 1 over input 2 (input 2 is treated as requesting output 1). Output 2 stays idle; o_input_grant=11000.
- Asynchronous reset mid-stream: drop reset_n between clock edges during contention traffic -> outputs clear immediately without a clock edge, and all pointers return to 0.
